// File: rtl/mc_control_fsm.sv
// mc_control_fsm: Moore-style main controller for the multicycle CPU datapath.
// It steps through fetch, decode, execute, memory and writeback. For each step it
// drives the PC/IR/register-file write enables and the mux/ALU selects. Memory
// steps (FETCH, MEMRD, MEMWR) are held until MemReady is seen high.
//
// Ports:
//   Clk       in   1  clock, rising edge
//   Reset     in   1  synchronous, active-high reset (state -> IDLE)
//   Op        in   6  opcode from IR[31:26], used in DECODE and MEMADR
//   Zero      in   1  ALU zero flag, gates PCWrite in BRANCH
//   MemReady  in   1  memory handshake that completes FETCH/MEMRD/MEMWR
//   PCWrite   out  1  PC write enable
//   IRWrite   out  1  IR write enable
//   RegWrite  out  1  register file write enable
//   MemRead   out  1  memory read strobe
//   MemWrite  out  1  memory write strobe
//   IorD      out  1  0=PC address, 1=ALUOut address
//   RegDst    out  1  0=rt, 1=rd
//   MemtoReg  out  1  0=ALUOut, 1=MDR
//   ALUSrcA   out  1  0=PC, 1=A
//   ALUSrcB   out  2  00=B, 01=4, 10=signext imm, 11=signext imm<<2
//   ALUOp     out  2  00=add, 01=sub, 10=funct
//   PCSource  out  2  00=ALU result, 01=ALUOut, 10=jump target
//   State     out  4  current state code
//   Trap      out  1  illegal-opcode flag
//
// Configuration macro ILLEGAL_TRAP_EN:
//   defined   -> an unknown opcode enters TRAP. TRAP holds until Reset, with Trap=1.
//   undefined -> an unknown opcode is a NOP (DECODE -> FETCH), and Trap is tied to 0.
//
// Outputs are decoded from the registered state, so they change only at clock edges.
// There are two exceptions. In FETCH, IRWrite and PCWrite follow MemReady. In BRANCH,
// PCWrite follows Zero.

module mc_control_fsm (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [5:0] Op,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IorD,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic [3:0] State,
  output logic       Trap
);

  localparam int unsigned OP_W = 6;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_RWB    = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_ADDIEX = 4'd11,
    S_ADDIWB = 4'd12,
    S_TRAP   = 4'd13
  } state_t;

  state_t r_state;
  state_t w_next_state;

  // State register. Reset overrides everything, including an instruction in progress.
  always_ff @(posedge Clk) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state and output decode
  always_comb begin
    w_next_state = S_FETCH;
    PCWrite      = 1'b0;
    IRWrite      = 1'b0;
    RegWrite     = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    IorD         = 1'b0;
    RegDst       = 1'b0;
    MemtoReg     = 1'b0;
    ALUSrcA      = 1'b0;
    ALUSrcB      = 2'b00;
    ALUOp        = 2'b00;
    PCSource     = 2'b00;
    Trap         = 1'b0;

    case (r_state)
      S_IDLE: w_next_state = S_FETCH;

      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        // Load IR and advance PC only in the cycle the memory completes.
        IRWrite = MemReady;
        PCWrite = MemReady;
        w_next_state = MemReady ? S_DECODE : S_FETCH;
      end

      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (Op)
          OP_LW, OP_SW: w_next_state = S_MEMADR;
          OP_RTYPE:     w_next_state = S_EXEC;
          OP_BEQ:       w_next_state = S_BRANCH;
          OP_ADDI:      w_next_state = S_ADDIEX;
          OP_J:         w_next_state = S_JUMP;
`ifdef ILLEGAL_TRAP_EN
          default:      w_next_state = S_TRAP;
`else
          default:      w_next_state = S_FETCH;
`endif
        endcase
      end

      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        w_next_state = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
      end

      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        w_next_state = MemReady ? S_MEMWB : S_MEMRD;
      end

      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        w_next_state = S_FETCH;
      end

      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        w_next_state = MemReady ? S_FETCH : S_MEMWR;
      end

      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
        w_next_state = S_RWB;
      end

      S_RWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
        w_next_state = S_FETCH;
      end

      S_BRANCH: begin
        ALUSrcA  = 1'b1;
        ALUOp    = 2'b01;
        PCSource = 2'b01;
        PCWrite  = Zero;
        w_next_state = S_FETCH;
      end

      S_JUMP: begin
        PCSource = 2'b10;
        PCWrite  = 1'b1;
        w_next_state = S_FETCH;
      end

      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        w_next_state = S_ADDIWB;
      end

      S_ADDIWB: begin
        RegWrite = 1'b1;
        w_next_state = S_FETCH;
      end

`ifdef ILLEGAL_TRAP_EN
      // Parked until Reset; every datapath enable stays low.
      S_TRAP: begin
        Trap = 1'b1;
        w_next_state = S_TRAP;
      end
`endif

      // Unused codes recover to FETCH with all outputs low.
      default: w_next_state = S_FETCH;
    endcase
  end

  assign State = r_state;

endmodule
